// File: rtl/regfile_dump.sv
// Debug read-out engine: walks a wrapping register-file address range through a
// dedicated read port and streams each 32-bit value as bytes over valid/ready.
module regfile_dump #(
  parameter int HDR_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  first_addr,
  input  logic [4:0]  last_addr,
  output logic        rd_en,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_B3   = 3'd3;
  localparam logic [2:0] S_B2   = 3'd4;
  localparam logic [2:0] S_B1   = 3'd5;
  localparam logic [2:0] S_B0   = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [4:0]  last_q, last_d;
  logic [31:0] shadow_q, shadow_d;
  logic        abort_q, abort_d;
  logic        accept;
  logic        abort_seen;

  function automatic logic [7:0] tx_byte(input logic [2:0] st, input logic [4:0] a,
                                         input logic [31:0] v);
    case (st)
      S_HDR:   return {3'b000, a};
      S_B3:    return v[31:24];
      S_B2:    return v[23:16];
      S_B1:    return v[15:8];
      S_B0:    return v[7:0];
      default: return 8'h00;
    endcase
  endfunction

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign rd_en    = (state_q == S_LOAD);
  assign rd_addr  = addr_q;
  assign tx_valid = (state_q >= S_HDR) && (state_q <= S_B0);
  assign tx_data  = tx_byte(state_q, addr_q, shadow_q);

  assign accept     = tx_valid && tx_ready;
  assign abort_seen = abort_q || abort;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_d   = last_q;
    shadow_d = shadow_q;
    abort_d  = abort_q;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          state_d = S_LOAD;
          addr_d  = first_addr;
          last_d  = last_addr;
        end
      end
      S_LOAD: begin
        // Snapshot is taken here; later writes only affect later registers.
        shadow_d = rd_data;
        if (abort_seen)      state_d = S_IDLE;
        else if (HDR_EN != 0) state_d = S_HDR;
        else                 state_d = S_B3;
      end
      S_HDR, S_B3, S_B2, S_B1: begin
        if (accept) state_d = abort_seen ? S_IDLE : 3'(state_q + 3'd1);
      end
      S_B0: begin
        if (accept) begin
          if (abort_seen) begin
            state_d = S_IDLE;
          end else if (addr_q == last_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            addr_d  = 5'(addr_q + 5'd1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (busy && abort) abort_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= 5'd0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      abort_q <= abort_d;
    end
  end

  // Datapath registers carry no reset; they are only observed when state says so.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
    last_q   <= last_d;
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: behavioural register file on the read port,
// per-cycle recording of accepted bytes, done pulses and read enables.
module tb_regfile_dump;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];

  int n_checks = 0;
  int n_err    = 0;

  // per-dump controls (-1 = unused)
  int rdy_mode, wr_cyc, abort_cyc, rst_cyc, restart_cyc;
  logic [4:0]  wr_a, restart_fa;
  logic [31:0] wr_v;

  // per-dump observations
  logic [7:0] bq[$];
  int         bc[$];
  logic [7:0] exp_b[$];
  int done_cyc, done_cnt, rden_cnt, rden_cyc, end_cyc, hold_err;
  logic busy1, end_tv;
  logic [4:0] end_addr;

  regfile_dump #(.HDR_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  // register file read port: index 0 hardwired to zero
  assign rd_data = (rd_addr == 5'd0) ? 32'd0 : rf[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_at(input int c);
    case (rdy_mode)
      1:       return (c % 5 == 0) || (c % 5 == 3);
      2:       return !(c == 5 || c == 6);
      default: return 1'b1;
    endcase
  endfunction

  task automatic clear_ctl();
    rdy_mode = 0; wr_cyc = -1; abort_cyc = -1; rst_cyc = -1; restart_cyc = -1;
    wr_a = 5'd0; wr_v = 32'd0; restart_fa = 5'd0;
  endtask

  // Cycle 0 is the cycle in which start is driven high.
  task automatic dump(input logic [4:0] fa, input logic [4:0] la);
    int cyc;
    logic prev_stall;
    logic [7:0] prev_d;
    bq.delete(); bc.delete();
    done_cyc = -1; done_cnt = 0; rden_cnt = 0; rden_cyc = -1; end_cyc = -1;
    hold_err = 0; busy1 = 1'b0; end_tv = 1'b1; end_addr = 5'h1F;
    first_addr = fa; last_addr = la; start = 1'b1; abort = 1'b0;
    tx_ready = ready_at(0);
    cyc = 0; prev_stall = 1'b0; prev_d = 8'h00;
    while (cyc < 300) begin
      step();
      cyc++;
      start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        first_addr = restart_fa;
        last_addr  = restart_fa;
      end
      abort    = (cyc == abort_cyc);
      rst      = !(cyc == rst_cyc);
      tx_ready = ready_at(cyc);
      if (cyc == wr_cyc) rf[wr_a] = wr_v;
      if (prev_stall && (!tx_valid || tx_data != prev_d)) hold_err++;
      if (cyc == 1) busy1 = busy;
      if (rd_en) begin rden_cnt++; rden_cyc = cyc; end
      if (done)  begin done_cnt++; done_cyc = cyc; end
      if (tx_valid && tx_ready) begin bq.push_back(tx_data); bc.push_back(cyc); end
      prev_stall = tx_valid && !tx_ready;
      prev_d     = tx_data;
      if (!busy) begin
        end_cyc  = cyc;
        end_tv   = tx_valid;
        end_addr = rd_addr;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; rst = 1'b1; tx_ready = 1'b1;
  endtask

  task automatic cmp_bytes(input string tag);
    check({tag, "_nbytes"}, bq.size(), exp_b.size());
    foreach (exp_b[i])
      check($sformatf("%s_b%0d", tag, i), (i < bq.size()) ? {24'd0, bq[i]} : 32'hFFFF_FFFF,
            {24'd0, exp_b[i]});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[0] = 32'hFFFF_FFFF;  // never visible: port returns 0 for index 0
    clear_ctl();
    rst = 1'b0; start = 1'b1; abort = 1'b0; tx_ready = 1'b1;
    first_addr = 5'd3; last_addr = 5'd4;

    // reset held two cycles with start asserted
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    rst = 1'b1; start = 1'b0;
    step();
    check("post_rst_busy", busy, 0);

    // single register
    rf[7] = 32'hDEADBEEF;
    dump(5'd7, 5'd7);
    exp_b = '{8'h07, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    cmp_bytes("single");
    foreach (bc[i]) check($sformatf("single_cyc%0d", i), bc[i], 2 + i);
    check("single_busy_c1", busy1, 1);
    check("single_done_cyc", done_cyc, 7);
    check("single_done_cnt", done_cnt, 1);
    check("single_rden_cnt", rden_cnt, 1);
    check("single_rden_cyc", rden_cyc, 1);
    check("single_end_cyc", end_cyc, 8);
    check("single_rd_addr_hold", end_addr, 7);

    // wrapping range 30..1
    rf[30] = 32'h11223344; rf[31] = 32'h55667788; rf[1] = 32'hA5A5A5A5;
    dump(5'd30, 5'd1);
    exp_b = '{8'h1E, 8'h11, 8'h22, 8'h33, 8'h44, 8'h1F, 8'h55, 8'h66, 8'h77, 8'h88,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    cmp_bytes("wrap");
    check("wrap_done_cyc", done_cyc, 25);
    check("wrap_rden_cnt", rden_cnt, 4);
    check("wrap_end_cyc", end_cyc, 26);

    // backpressure: ready pattern 1,0,0,1,0 repeating, range 30..31
    rdy_mode = 1;
    dump(5'd30, 5'd31);
    exp_b = '{8'h1E, 8'h11, 8'h22, 8'h33, 8'h44, 8'h1F, 8'h55, 8'h66, 8'h77, 8'h88};
    cmp_bytes("bp");
    begin
      int exp_c[10] = '{3, 5, 8, 10, 13, 15, 18, 20, 23, 25};
      foreach (exp_c[i])
        check($sformatf("bp_cyc%0d", i), (i < bc.size()) ? bc[i] : -1, exp_c[i]);
    end
    check("bp_hold_err", hold_err, 0);
    check("bp_done_cyc", done_cyc, 26);
    check("bp_end_cyc", end_cyc, 27);
    clear_ctl();

    // snapshot: r8 overwritten while its B2 byte is on the wire
    rf[8] = 32'hCAFEF00D;
    wr_cyc = 4; wr_a = 5'd8; wr_v = 32'h0;
    dump(5'd8, 5'd8);
    exp_b = '{8'h08, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    cmp_bytes("snap");
    check("snap_done_cnt", done_cnt, 1);
    clear_ctl();
    dump(5'd8, 5'd8);
    exp_b = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
    cmp_bytes("snap_after");

    // abort during B1 while stalled
    rf[9] = 32'h12345678;
    rdy_mode = 2; abort_cyc = 5;
    dump(5'd9, 5'd9);
    exp_b = '{8'h09, 8'h12, 8'h34, 8'h56};
    cmp_bytes("abort");
    check("abort_b1_cyc", (bc.size() == 4) ? bc[3] : -1, 7);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_end_cyc", end_cyc, 8);
    clear_ctl();

    // abort in LOAD
    abort_cyc = 1;
    dump(5'd9, 5'd9);
    check("abort_load_nbytes", bq.size(), 0);
    check("abort_load_done_cnt", done_cnt, 0);
    check("abort_load_end_cyc", end_cyc, 2);
    clear_ctl();

    // start while busy is ignored
    rf[2] = 32'h01020304; rf[3] = 32'h0A0B0C0D; rf[10] = 32'hBADBADBA;
    restart_cyc = 3; restart_fa = 5'd10;
    dump(5'd2, 5'd3);
    exp_b = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    cmp_bytes("ignore");
    check("ignore_done_cyc", done_cyc, 13);
    check("ignore_done_cnt", done_cnt, 1);
    clear_ctl();

    // reset during B3, then a normal dump
    rst_cyc = 3;
    dump(5'd7, 5'd7);
    check("midrst_end_cyc", end_cyc, 4);
    check("midrst_tx_valid", end_tv, 0);
    check("midrst_rd_addr", end_addr, 0);
    check("midrst_done_cnt", done_cnt, 0);
    clear_ctl();
    dump(5'd7, 5'd7);
    exp_b = '{8'h07, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    cmp_bytes("after_rst");
    check("after_rst_done_cyc", done_cyc, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine on the opposite side of the register file's write port: it walks a contiguous, wrapping address range through a dedicated register-file read port. It snapshots each 32-bit value and streams it out as a byte sequence over a valid/ready handshake. It sits beside the CPU core, feeding the board's serial/debug transmitter, so register state can be inspected without halting the pipeline.

## Interface
Parameters:
- HDR_EN, default 1: when 1, each register is preceded by an address header byte; when 0, only the data bytes are sent.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-low.
- start  input  1  request a dump; sampled only in IDLE.
- abort  input  1  terminate the dump at the next byte boundary.
- first_addr  input  5  first register index, sampled with start.
- last_addr  input  5  last register index, sampled with start.
- rd_en  output  1  read-port enable to the register file.
- rd_addr  output  5  read-port register index.
- rd_data  input  32  read-port data; combinational from the register file.
- tx_data  output  8  outgoing byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts the byte this cycle.
- busy  output  1  dump in progress (any state other than IDLE).
- done  output  1  one-cycle pulse on normal completion.

## Operation
- States:
  - IDLE: waits for start.
  - LOAD: rd_en=1; rd_data is captured into a 32-bit shadow register at the end of the cycle.
  - HDR: tx_data={3'b000,rd_addr}; skipped when HDR_EN=0.
  - B3, B2, B1, B0: data bytes, big-endian (B3 = bits 31:24).
  - DONE: completion state.
- Transitions:
  - IDLE→LOAD on start.
  - LOAD→HDR (or B3 when HDR_EN=0).
  - Each byte state advances only on tx_valid&&tx_ready.
  - After B0 is accepted:
    - abort seen since the last boundary → IDLE;
    - otherwise, last register sent → DONE;
    - otherwise → LOAD with rd_addr+1 (mod 32).
  - DONE→IDLE.
- Range and count:
  - Register count = ((last_addr-first_addr) mod 32)+1, range 1..32.
  - last<first wraps through 31→0.
  - first==last dumps one register.
  - first=0, last=31 dumps all 32.
- Snapshot: the value is frozen in LOAD. Register-file writes after that cycle do not alter bytes of the register in flight; they are visible only to later registers.
- Index 0 is read like any other index; it always yields 0 from the register file.
- start while busy is ignored. first_addr and last_addr are not re-sampled.
- abort:
  - Latched when asserted while busy.
  - If tx_valid is high, the current byte is held until accepted; the dump then ends (IDLE, no done pulse).
  - abort in LOAD → IDLE next cycle, with no byte emitted.
- Handshake: once tx_valid rises, tx_valid and tx_data stay constant until tx_ready. tx_valid is never withdrawn except by reset.
- rd_en is high only in LOAD. rd_addr holds its last value otherwise.

## Timing
- Reset values: tx_valid=0, tx_data=0, rd_en=0, rd_addr=0, busy=0, done=0; state IDLE; abort latch cleared.
- Reset wins over all other inputs. A reset mid-dump drops any pending byte with no done pulse.
- Latency (start high in cycle 0, tx_ready=1 throughout, HDR_EN=1):
  - busy=1 and LOAD in cycle 1.
  - Header in cycle 2; data bytes in cycles 3-6.
  - 6 cycles per register; 5 when HDR_EN=0.
  - For N registers, DONE (done=1, busy=1) is in cycle 6N+1; busy=0 in cycle 6N+2.
- Backpressure adds exactly one cycle per cycle of tx_ready=0 while tx_valid=1.
- start is honoured in the same cycle that DONE returns to IDLE only if seen in IDLE, i.e. one cycle after done.

## Test plan
- Reset: rst=0 for 2 cycles with start=1 and tx_ready=1 → all outputs 0, no LOAD; after release, busy=0.
- Single register: r7=0xDEADBEEF, first=last=7, tx_ready=1, start in cycle 0 → bytes 07,DE,AD,BE,EF in cycles 2-6, done=1 only in cycle 7, rd_en=1 only in cycle 1.
- Wrap range: first=30, last=1, r30=0x11223344, r31=0x55667788, r1=0xA5A5A5A5 → 20 bytes; address order 1E,1F,00,01; r0 bytes all 00.
- Backpressure: tx_ready follows pattern 1,0,0,1,0,… → tx_data stable while stalled, no byte lost or duplicated, done delayed by exactly the number of stalled cycles.
- Snapshot and abort: write r8 := 0x0 while r8=0xCAFEF00D is at B2 → bytes CA,FE,F0,0D unchanged. abort during B1 with tx_ready=0 → B1 held until accepted, then IDLE, no B0, no done.
- Ignore and reset: start pulsed while busy → no restart, range unchanged. rst=0 during B3 → tx_valid=0 next cycle, IDLE, a subsequent start works normally.
